// File: rtl/fib_arb_ctrl.sv
// Round-robin arbiter sharing one Fibonacci generator between two requesters.
// Each job releases the generator from reset and streams N terms, or fewer if the output wraps.
module fib_arb_ctrl #(
  parameter int unsigned FibBits = 10,
  parameter int unsigned CntBits = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [CntBits-1:0] len0,
  input  logic [CntBits-1:0] len1,
  output logic [1:0]         ack,
  output logic               busy,
  output logic               out_valid,
  output logic [FibBits-1:0] out_data,
  output logic               out_id,
  output logic               out_last,
  output logic               out_ovf,
  output logic               gen_nrst,
  input  logic [FibBits-1:0] gen_f
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_last_id, w_last_id_nxt;
  logic               r_id, w_id_nxt;
  logic [CntBits-1:0] r_len, w_len_nxt;
  logic [CntBits-1:0] r_k, w_k_nxt;
  logic [FibBits-1:0] r_prev, w_prev_nxt;
  logic [1:0]         r_ack, w_ack_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_valid, w_valid_nxt;
  logic [FibBits-1:0] r_data, w_data_nxt;
  logic               r_out_id, w_out_id_nxt;
  logic               r_last, w_last_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_nrst, w_nrst_nxt;

  logic               w_gnt;
  logic [CntBits-1:0] w_len_sel;
  logic               w_wrap;

  // With both pending, serve whoever was not served last.
  assign w_gnt     = (req[0] && req[1]) ? ~r_last_id : req[1];
  assign w_len_sel = w_gnt ? len1 : len0;
  // A sum that falls below its predecessor has wrapped; the first two terms cannot wrap.
  assign w_wrap    = (r_k >= CntBits'(2)) && (gen_f < r_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_len     <= '0;
      r_k       <= '0;
      r_prev    <= '0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_out_id  <= 1'b0;
      r_last    <= 1'b0;
      r_ovf     <= 1'b0;
      r_nrst    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_id <= w_last_id_nxt;
      r_id      <= w_id_nxt;
      r_len     <= w_len_nxt;
      r_k       <= w_k_nxt;
      r_prev    <= w_prev_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_valid   <= w_valid_nxt;
      r_data    <= w_data_nxt;
      r_out_id  <= w_out_id_nxt;
      r_last    <= w_last_nxt;
      r_ovf     <= w_ovf_nxt;
      r_nrst    <= w_nrst_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_id_nxt = r_last_id;
    w_id_nxt      = r_id;
    w_len_nxt     = r_len;
    w_k_nxt       = r_k;
    w_prev_nxt    = r_prev;
    w_ack_nxt     = '0;
    w_busy_nxt    = 1'b0;
    w_valid_nxt   = 1'b0;
    w_data_nxt    = r_data;
    w_out_id_nxt  = r_out_id;
    w_last_nxt    = 1'b0;
    w_ovf_nxt     = 1'b0;
    w_nrst_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_ack_nxt     = w_gnt ? 2'b10 : 2'b01;
          w_id_nxt      = w_gnt;
          w_len_nxt     = w_len_sel;
          w_last_id_nxt = w_gnt;
          // A zero-length job is acknowledged without starting the generator.
          if (w_len_sel != '0) begin
            w_state_nxt = S_RUN;
            w_busy_nxt  = 1'b1;
            w_nrst_nxt  = 1'b1;
            w_k_nxt     = '0;
          end
        end
      end
      S_RUN: begin
        w_valid_nxt  = 1'b1;
        w_data_nxt   = gen_f;
        w_out_id_nxt = r_id;
        w_prev_nxt   = gen_f;
        w_k_nxt      = CntBits'(r_k + 1'b1);
        w_busy_nxt   = 1'b1;
        w_nrst_nxt   = 1'b1;
        if (w_wrap) begin
          w_ovf_nxt   = 1'b1;
          w_last_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_nrst_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_k == CntBits'(r_len - 1'b1)) begin
          w_last_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_nrst_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_out_id;
  assign out_last  = r_last;
  assign out_ovf   = r_ovf;
  assign gen_nrst  = r_nrst;

endmodule

// File: tb/tb_fib_arb_ctrl.sv
// Scoreboard bench for fib_arb_ctrl driving a behavioural Fibonacci generator.
module tb_fib_arb_ctrl;
  localparam int unsigned FB = 10;
  localparam int unsigned CB = 5;

  typedef struct packed {
    logic [FB-1:0] data;
    logic          id;
    logic          last;
    logic          ovf;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [CB-1:0] len0, len1;
  logic [1:0]    ack;
  logic          busy, out_valid, out_id, out_last, out_ovf, gen_nrst;
  logic [FB-1:0] out_data, gen_f;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    fibv[18] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987, 573};

  fib_arb_ctrl #(.FibBits(FB), .CntBits(CB)) dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1), .ack(ack),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .out_ovf(out_ovf), .gen_nrst(gen_nrst), .gen_f(gen_f)
  );

  always #5 clk = ~clk;

  // Generator: held at 0 while nrst is low, advances one term per edge otherwise.
  logic [FB-1:0] fa, fb;
  always_ff @(posedge clk or negedge gen_nrst) begin
    if (!gen_nrst) begin
      fa <= '0;
      fb <= FB'(1);
    end else begin
      fa <= fb;
      fb <= FB'(fa + fb);
    end
  end
  assign gen_f = fa;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input bit id, input bit last, input bit ovf);
    exp_q.push_back(beat_t'({FB'(d), id, last, ovf}));
  endtask

  task automatic monitor();
    beat_t a, e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        a = beat_t'({out_data, out_id, out_last, out_ovf});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", a, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", a, e);
          if (out_last === 1'b1) begin
            check("busy_at_last", busy, 0);
            check("nrst_at_last", gen_nrst, 0);
          end else begin
            check("busy_mid_job", busy, 1);
          end
        end
      end
    end
  endtask

  // Waits for ack[i]; checks the accept cycle and the first-beat cycle after it.
  task automatic wait_ack(input int i, input int len, input bit drop, output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (ack[i] === 1'b1) break;
    end
    if (ack[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got ack=%b expected ack[%0d]=1", ack, i);
      return;
    end
    check("ack_onehot", ack, (i == 1) ? 2'b10 : 2'b01);
    check("busy_after_ack", busy, (len != 0) ? 1 : 0);
    check("nrst_after_ack", gen_nrst, (len != 0) ? 1 : 0);
    if (drop) req[i] = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", ack, 0);
    check("first_beat_valid", out_valid, (len != 0) ? 1 : 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
  endtask

  task automatic arb_pair();
    int n;
    len0 = CB'(3);
    len1 = CB'(4);
    push(0, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 1, 0);
    push(0, 1, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0); push(2, 1, 1, 0);
    req = 2'b11;
    wait_ack(0, 3, 1'b1, n);
    wait_ack(1, 4, 1'b1, n);
    check("b2b_ack_gap", n, 3);
    drain();
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    req  = 2'b00;
    len0 = '0;
    len1 = '0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ack, busy, out_valid, out_data, out_id, out_last, out_ovf, gen_nrst}, 0);
    @(negedge clk) rst = 1'b0;

    // Single job of 5 terms
    len0 = CB'(5);
    push(0, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 0, 1, 0);
    req[0] = 1'b1;
    wait_ack(0, 5, 1'b1, n);
    drain();

    // Overflow truncates a 20-term job after the wrapped term
    len0 = CB'(20);
    for (int i = 0; i < 17; i++) push(fibv[i], 0, 0, 0);
    push(fibv[17], 0, 1, 1);
    req[0] = 1'b1;
    wait_ack(0, 20, 1'b1, n);
    drain();

    // Arbitration from a fresh reset, then re-raised
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    arb_pair();
    arb_pair();

    // Zero-length and one-length jobs
    len1 = CB'(0);
    req[1] = 1'b1;
    wait_ack(1, 0, 1'b1, n);
    @(posedge clk); #1;
    check("zero_len_busy", busy, 0);
    len1 = CB'(1);
    push(0, 1, 1, 0);
    req[1] = 1'b1;
    wait_ack(1, 1, 1'b1, n);
    drain();

    // Reset during term 4 discards the job; held request restarts from 0
    len0 = CB'(10);
    push(0, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0);
    req[0] = 1'b1;
    wait_ack(0, 10, 1'b0, n);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("reset_async", {ack, busy, out_valid, out_data, out_id, out_last, out_ovf, gen_nrst}, 0);
    check("beats_before_reset", exp_q.size(), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 9; i++) push(fibv[i], 0, 0, 0);
    push(fibv[9], 0, 1, 0);
    wait_ack(0, 10, 1'b1, n);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
